// File: rtl/output_token_writer.sv
// rtl/output_token_writer.sv - queues result/status pairs and writes them as two 16-bit tokens, high word first
module output_token_writer #(
    parameter int WORD_SIZE   = 16,
    parameter int BUFFER_SIZE = 1024,
    parameter int Q_DEPTH     = 4,
    localparam int AW = $clog2(BUFFER_SIZE),
    localparam int QW = $clog2(Q_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_rst_instr,
    input  logic                   i_en_wr_output_fifo,
    input  logic [2*WORD_SIZE-1:0] i_result,
    input  logic [2*WORD_SIZE-1:0] i_status,
    input  logic [AW-1:0]          i_pop_out_fifo_result,
    input  logic [AW-1:0]          i_pop_out_fifo_status,
    output logic                   o_wr_out_result,
    output logic                   o_wr_out_status,
    output logic [WORD_SIZE-1:0]   o_data_out_result,
    output logic [WORD_SIZE-1:0]   o_data_out_status,
    output logic [QW:0]            o_pending,
    output logic                   o_busy,
    output logic                   o_overflow
);

    typedef enum logic [1:0] {IDLE, CHECK, WR_HI, WR_LO} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [2*WORD_SIZE-1:0] r_q_result [Q_DEPTH];
    logic [2*WORD_SIZE-1:0] r_q_status [Q_DEPTH];
    logic [QW-1:0]          r_wptr;
    logic [QW-1:0]          r_rptr;
    logic [QW:0]            r_count;
    logic                   r_overflow;
    logic                   r_clr_pend;

    logic                   w_deq;
    logic                   w_full;
    logic                   w_strobe;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_clear_lo;
    logic                   w_clear;
    logic [QW:0]            w_count_next;
    logic [AW:0]            w_free_result;
    logic [AW:0]            w_free_status;
    logic                   w_space_ok;
    logic [2*WORD_SIZE-1:0] w_head_result;
    logic [2*WORD_SIZE-1:0] w_head_status;

    assign w_deq      = (r_state == WR_LO);
    assign w_full     = (r_count == (QW+1)'(Q_DEPTH));
    assign w_strobe   = i_en_wr_output_fifo && i_rst_instr;
    // A full queue still takes a strobe when the head leaves on the same edge.
    assign w_push     = w_strobe && (!w_full || w_deq);
    assign w_drop     = w_strobe && w_full && !w_deq;
    // An instruction reset seen during a pair is deferred to the WR_LO edge.
    assign w_clear_lo = w_deq && (!i_rst_instr || r_clr_pend);
    assign w_clear    = w_clear_lo || (!i_rst_instr && (r_state == IDLE || r_state == CHECK));
    assign w_count_next = r_count + (QW+1)'(w_push) - (QW+1)'(w_deq);

    assign w_free_result = (AW+1)'(BUFFER_SIZE) - {1'b0, i_pop_out_fifo_result};
    assign w_free_status = (AW+1)'(BUFFER_SIZE) - {1'b0, i_pop_out_fifo_status};
    assign w_space_ok    = (w_free_result >= (AW+1)'(2)) && (w_free_status >= (AW+1)'(2));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_rst_instr && r_count != '0) w_state_next = CHECK;
            CHECK:   if (!i_rst_instr)                 w_state_next = IDLE;
                     else if (w_space_ok)              w_state_next = WR_HI;
            WR_HI:   w_state_next = WR_LO;
            WR_LO:   if (!w_clear_lo && w_count_next != '0) w_state_next = CHECK;
                     else                                   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_clr_pend <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_clear) begin
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
                r_clr_pend <= 1'b0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_deq)  r_rptr <= r_rptr + 1'b1;
                r_count <= w_count_next;
                if (w_drop) r_overflow <= 1'b1;
                if (r_state == WR_HI && !i_rst_instr) r_clr_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_result[r_wptr] <= i_result;
            r_q_status[r_wptr] <= i_status;
        end
    end

    assign w_head_result = r_q_result[r_rptr];
    assign w_head_status = r_q_status[r_rptr];

    always_comb begin
        o_wr_out_result   = 1'b0;
        o_wr_out_status   = 1'b0;
        o_data_out_result = '0;
        o_data_out_status = '0;
        if (r_state == WR_HI) begin
            o_wr_out_result   = 1'b1;
            o_wr_out_status   = 1'b1;
            o_data_out_result = w_head_result[2*WORD_SIZE-1:WORD_SIZE];
            o_data_out_status = w_head_status[2*WORD_SIZE-1:WORD_SIZE];
        end else if (r_state == WR_LO) begin
            o_wr_out_result   = 1'b1;
            o_wr_out_status   = 1'b1;
            o_data_out_result = w_head_result[WORD_SIZE-1:0];
            o_data_out_status = w_head_status[WORD_SIZE-1:0];
        end
    end

    assign o_pending  = r_count;
    assign o_busy     = (r_state != IDLE);
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_output_token_writer.sv
// tb/tb_output_token_writer.sv - directed self-checking bench for output_token_writer
module tb_output_token_writer;

    logic        clk = 1'b0;
    logic        rst, rst_instr, en;
    logic [31:0] res, sta;
    logic [9:0]  pop_r, pop_s;
    logic        wr_r, wr_s, busy, overflow;
    logic [15:0] d_r, d_s;
    logic [2:0]  pending;
    logic [38:0] obs;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] got_r[$];
    logic [15:0] got_s[$];

    always #5 clk = ~clk;

    output_token_writer dut (
        .clk                   (clk),
        .rst                   (rst),
        .i_rst_instr           (rst_instr),
        .i_en_wr_output_fifo   (en),
        .i_result              (res),
        .i_status              (sta),
        .i_pop_out_fifo_result (pop_r),
        .i_pop_out_fifo_status (pop_s),
        .o_wr_out_result       (wr_r),
        .o_wr_out_status       (wr_s),
        .o_data_out_result     (d_r),
        .o_data_out_status     (d_s),
        .o_pending             (pending),
        .o_busy                (busy),
        .o_overflow            (overflow)
    );

    // {wr_r, wr_s, d_r, d_s, pending, busy, overflow}
    assign obs = {wr_r, wr_s, d_r, d_s, pending, busy, overflow};

    always @(negedge clk) begin
        if (wr_r) begin
            got_r.push_back(d_r);
            got_s.push_back(d_s);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; rst_instr = 1'b1; en = 1'b0; res = '0; sta = '0; pop_r = '0; pop_s = '0;
        tick(); tick();
        n_cmp++;
        if (obs !== 39'h0) begin
            n_bad++; $display("FAIL reset_state: got %h want %h", obs, 39'h0);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        got_r.delete(); got_s.delete();
        en = 1'b1; res = 32'h1234ABCD; sta = 32'h00000001;
        tick(); en = 1'b0;
        n_cmp++;
        if (obs !== {2'b00, 32'h0, 3'd1, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL single_captured: got %h want %h", obs, {2'b00, 32'h0, 3'd1, 1'b0, 1'b0});
        end
        tick();
        n_cmp++;
        if (obs !== {2'b00, 32'h0, 3'd1, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL single_check: got %h want %h", obs, {2'b00, 32'h0, 3'd1, 1'b1, 1'b0});
        end
        tick();
        n_cmp++;
        if (obs !== {2'b11, 16'h1234, 16'h0000, 3'd1, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL single_hi: got %h want %h", obs, {2'b11, 16'h1234, 16'h0000, 3'd1, 1'b1, 1'b0});
        end
        tick();
        n_cmp++;
        if (obs !== {2'b11, 16'hABCD, 16'h0001, 3'd1, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL single_lo: got %h want %h", obs, {2'b11, 16'hABCD, 16'h0001, 3'd1, 1'b1, 1'b0});
        end
        tick();
        n_cmp++;
        if (obs !== 39'h0) begin
            n_bad++; $display("FAIL single_idle: got %h want %h", obs, 39'h0);
        end
    endtask

    task automatic test_backpressure();
        got_r.delete(); got_s.delete();
        pop_r = 10'd1023;
        en = 1'b1; res = 32'hCAFEBEEF; sta = 32'h00020003;
        tick(); en = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (obs !== {2'b00, 32'h0, 3'd1, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL bp_result_hold: got %h want %h", obs, {2'b00, 32'h0, 3'd1, 1'b1, 1'b0});
        end
        pop_r = 10'd0; pop_s = 10'd1023;
        repeat (3) tick();
        n_cmp++;
        if (obs !== {2'b00, 32'h0, 3'd1, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL bp_status_hold: got %h want %h", obs, {2'b00, 32'h0, 3'd1, 1'b1, 1'b0});
        end
        n_cmp++;
        if (got_r.size() != 0) begin
            n_bad++; $display("FAIL bp_no_writes: got %0d tokens want 0", got_r.size());
        end
        pop_s = 10'd1022;
        tick();
        n_cmp++;
        if (obs !== {2'b11, 16'hCAFE, 16'h0002, 3'd1, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL bp_hi: got %h want %h", obs, {2'b11, 16'hCAFE, 16'h0002, 3'd1, 1'b1, 1'b0});
        end
        tick();
        n_cmp++;
        if (obs !== {2'b11, 16'hBEEF, 16'h0003, 3'd1, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL bp_lo: got %h want %h", obs, {2'b11, 16'hBEEF, 16'h0003, 3'd1, 1'b1, 1'b0});
        end
        pop_s = 10'd0;
        tick();
    endtask

    task automatic test_burst_overflow();
        logic [31:0] exp_r[$];
        logic [31:0] exp_s[$];
        got_r.delete(); got_s.delete();
        pop_r = 10'd1023;
        for (int k = 1; k <= 5; k++) begin
            en = 1'b1; res = {16'(k), 16'h0100 + 16'(k)}; sta = {16'h0A00 + 16'(k), 16'h0B00 + 16'(k)};
            if (k <= 4) begin exp_r.push_back(res); exp_s.push_back(sta); end
            tick();
        end
        en = 1'b0;
        n_cmp++;
        if (pending !== 3'd4 || overflow !== 1'b1) begin
            n_bad++; $display("FAIL burst_full: got pending=%0d ovf=%b want pending=4 ovf=1", pending, overflow);
        end
        pop_r = 10'd0;
        for (int i = 0; i < 10 && !wr_r; i++) tick();
        n_cmp++;
        if (wr_r !== 1'b1) begin
            n_bad++; $display("FAIL burst_wait_wr: got wr=%b want 1", wr_r);
        end
        tick();
        en = 1'b1; res = 32'h00060106; sta = 32'h0A060B06;
        exp_r.push_back(res); exp_s.push_back(sta);
        tick(); en = 1'b0;
        n_cmp++;
        if (pending !== 3'd4 || overflow !== 1'b1) begin
            n_bad++; $display("FAIL burst_refill: got pending=%0d ovf=%b want pending=4 ovf=1", pending, overflow);
        end
        for (int i = 0; i < 60 && busy; i++) tick();
        n_cmp++;
        if (got_r.size() != 10 || busy !== 1'b0) begin
            n_bad++; $display("FAIL burst_drain: got %0d tokens busy=%b want 10 tokens busy=0", got_r.size(), busy);
        end
        for (int i = 0; i < 10 && i < got_r.size(); i++) begin
            n_cmp++;
            if (got_r[i] !== (i[0] ? exp_r[i/2][15:0] : exp_r[i/2][31:16]) ||
                got_s[i] !== (i[0] ? exp_s[i/2][15:0] : exp_s[i/2][31:16])) begin
                n_bad++;
                $display("FAIL burst_token%0d: got %h/%h want %h/%h", i, got_r[i], got_s[i],
                         i[0] ? exp_r[i/2][15:0] : exp_r[i/2][31:16], i[0] ? exp_s[i/2][15:0] : exp_s[i/2][31:16]);
            end
        end
    endtask

    task automatic test_rst_instr_mid_pair();
        got_r.delete(); got_s.delete();
        pop_r = 10'd1023;
        for (int k = 0; k < 3; k++) begin
            en = 1'b1; res = 32'hA0A0_0000 + 32'(k); sta = 32'h5050_0000 + 32'(k);
            tick();
        end
        en = 1'b0;
        n_cmp++;
        if (pending !== 3'd3 || overflow !== 1'b1) begin
            n_bad++; $display("FAIL ri_queued: got pending=%0d ovf=%b want pending=3 ovf=1", pending, overflow);
        end
        pop_r = 10'd0;
        for (int i = 0; i < 10 && !wr_r; i++) tick();
        n_cmp++;
        if (d_r !== 16'hA0A0 || d_s !== 16'h5050) begin
            n_bad++; $display("FAIL ri_hi: got %h/%h want a0a0/5050", d_r, d_s);
        end
        rst_instr = 1'b0;
        tick();
        rst_instr = 1'b1;
        n_cmp++;
        if (obs !== {2'b11, 16'h0000, 16'h0000, 3'd3, 1'b1, 1'b1}) begin
            n_bad++; $display("FAIL ri_lo: got %h want %h", obs, {2'b11, 16'h0000, 16'h0000, 3'd3, 1'b1, 1'b1});
        end
        tick();
        n_cmp++;
        if (obs !== 39'h0) begin
            n_bad++; $display("FAIL ri_cleared: got %h want %h", obs, 39'h0);
        end
        repeat (5) tick();
        n_cmp++;
        if (got_r.size() != 2 || busy !== 1'b0) begin
            n_bad++; $display("FAIL ri_discard: got %0d tokens busy=%b want 2 tokens busy=0", got_r.size(), busy);
        end
    endtask

    task automatic test_full_coincident();
        got_r.delete(); got_s.delete();
        pop_r = 10'd1023;
        en = 1'b1; res = 32'h11112222; sta = 32'h33334444;
        tick(); en = 1'b0;
        tick(); tick();
        rst_instr = 1'b0; en = 1'b1;
        tick();
        rst_instr = 1'b1; en = 1'b0;
        n_cmp++;
        if (pending !== 3'd0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL check_clear: got pending=%0d busy=%b want pending=0 busy=0", pending, busy);
        end
        for (int k = 0; k < 4; k++) begin
            en = 1'b1; res = 32'hC0DE_0000 + 32'(k); sta = 32'hD00D_0000 + 32'(k);
            tick();
        end
        en = 1'b0;
        n_cmp++;
        if (pending !== 3'd4 || overflow !== 1'b0) begin
            n_bad++; $display("FAIL fc_full: got pending=%0d ovf=%b want pending=4 ovf=0", pending, overflow);
        end
        pop_r = 10'd0;
        for (int i = 0; i < 10 && !wr_r; i++) tick();
        tick();
        en = 1'b1; res = 32'hE1E2E3E4; sta = 32'hF1F2F3F4;
        tick(); en = 1'b0;
        n_cmp++;
        if (pending !== 3'd4 || overflow !== 1'b0) begin
            n_bad++; $display("FAIL fc_accept: got pending=%0d ovf=%b want pending=4 ovf=0", pending, overflow);
        end
        for (int i = 0; i < 60 && busy; i++) tick();
        n_cmp++;
        if (got_r.size() != 10) begin
            n_bad++; $display("FAIL fc_count: got %0d tokens want 10", got_r.size());
        end else if (got_r[8] !== 16'hE1E2 || got_r[9] !== 16'hE3E4 || got_s[8] !== 16'hF1F2 || got_s[9] !== 16'hF3F4) begin
            n_bad++; $display("FAIL fc_last_pair: got %h%h/%h%h want e1e2e3e4/f1f2f3f4", got_r[8], got_r[9], got_s[8], got_s[9]);
        end
    endtask

    task automatic test_async_rst();
        en = 1'b1; res = 32'h77778888; sta = 32'h9999AAAA;
        tick();
        res = 32'h12121313; sta = 32'h14141515;
        tick(); en = 1'b0;
        for (int i = 0; i < 10 && !wr_r; i++) tick();
        tick();
        n_cmp++;
        if (obs !== {2'b11, 16'h8888, 16'hAAAA, 3'd2, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL ar_lo: got %h want %h", obs, {2'b11, 16'h8888, 16'hAAAA, 3'd2, 1'b1, 1'b0});
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 39'h0) begin
            n_bad++; $display("FAIL ar_abort: got %h want %h", obs, 39'h0);
        end
        tick();
        rst = 1'b1;
        tick();
        got_r.delete(); got_s.delete();
        en = 1'b1; res = 32'h0BADF00D; sta = 32'h00C0FFEE;
        tick(); en = 1'b0;
        for (int i = 0; i < 20 && (busy || pending != 0); i++) tick();
        n_cmp++;
        if (got_r.size() != 2) begin
            n_bad++; $display("FAIL ar_resume_count: got %0d tokens want 2", got_r.size());
        end else if (got_r[0] !== 16'h0BAD || got_r[1] !== 16'hF00D || got_s[0] !== 16'h00C0 || got_s[1] !== 16'hFFEE) begin
            n_bad++; $display("FAIL ar_resume_data: got %h%h/%h%h want 0badf00d/00c0ffee", got_r[0], got_r[1], got_s[0], got_s[1]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_burst_overflow();
        test_rst_instr_mid_pair();
        test_full_coincident();
        test_async_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
